// File: rtl/tamsayi_fp_cevirici_pkg.sv
// Shared definitions for the integer/float blocks: FSM state encoding, exponent bias helper and
// the standard IEEE-754 format widths.
package tamsayi_fp_cevirici_pkg;

   localparam logic [2:0] BOS     = 3'd0;
   localparam logic [2:0] MUTLAK  = 3'd1;
   localparam logic [2:0] NORM    = 3'd2;
   localparam logic [2:0] YUVARLA = 3'd3;
   localparam logic [2:0] BITTI   = 3'd4;

   localparam int unsigned FP16_B = 16;
   localparam int unsigned FP16_E = 5;
   localparam int unsigned FP16_M = 10;
   localparam int unsigned FP32_B = 32;
   localparam int unsigned FP32_E = 8;
   localparam int unsigned FP32_M = 23;
   localparam int unsigned FP64_B = 64;
   localparam int unsigned FP64_E = 11;
   localparam int unsigned FP64_M = 52;

   function automatic int unsigned bias(input int unsigned ew);
      return (1 << (ew - 1)) - 1;
   endfunction

endpackage

// File: rtl/tamsayi_fp_cevirici_if.sv
// Request/response bundle of the integer-to-float converter.
interface tamsayi_fp_cevirici_if
   import tamsayi_fp_cevirici_pkg::*;
#(
   parameter int unsigned IW = 32,
   parameter int unsigned b  = FP32_B
);
   logic          start_i;
   logic          isaretli_i;
   logic [IW-1:0] tamsayi_i;
   logic          ready_o;
   logic          valid_o;
   logic [b-1:0]  sonuc_o;

   modport master (
      output start_i, isaretli_i, tamsayi_i,
      input  ready_o, valid_o, sonuc_o
   );

   modport slave (
      input  start_i, isaretli_i, tamsayi_i,
      output ready_o, valid_o, sonuc_o
   );
endinterface

// File: rtl/tamsayi_fp_cevirici_oncu_sifir_sayaci.sv
// Combinational IW-bit leading-zero counter, used by the FAST_NORM_EN build.
// An all-zero input reports IW-1.
module oncu_sifir_sayaci #(
   parameter int unsigned IW = 32
) (
   input  logic [IW-1:0]         i_veri,
   output logic [$clog2(IW)-1:0] o_sayi
);
   localparam int unsigned LW = $clog2(IW);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      o_sayi = LW'(IW - 1);
      for (int i = 0; i < IW; i++) begin
         if (i_veri[i]) o_sayi = LW'(IW - 1 - i);
      end
   end
endmodule

// File: rtl/tamsayi_fp_cevirici.sv
// Multi-cycle integer to IEEE-754 converter with round-to-nearest-even.
// Define FAST_NORM_EN for single-cycle normalisation; otherwise NORM shifts one bit per cycle.
module tamsayi_fp_cevirici
   import tamsayi_fp_cevirici_pkg::*;
#(
   parameter int unsigned b  = FP32_B,
   parameter int unsigned e  = FP32_E,
   parameter int unsigned m  = FP32_M,
   parameter int unsigned IW = 32
) (
   input logic                  clk_i,
   input logic                  rst_i,
   input logic                  en_i,
   tamsayi_fp_cevirici_if.slave arayuz
);
   localparam logic [e-1:0] EXP_BAS = e'(bias(e) + IW - 1);
   localparam int unsigned  GW      = IW - 1 + m + 2;

   logic [2:0]    r_durum, w_durum;
   logic [IW-1:0] r_tamsayi, w_tamsayi;
   logic          r_isaretli, w_isaretli;
   logic          r_isaret, w_isaret;
   logic [IW-1:0] r_mag, w_mag;
   logic [e-1:0]  r_exp, w_exp;
   logic [b-1:0]  r_sonuc, w_sonuc;
   logic          r_valid;

   logic          w_negatif;
   logic [IW-1:0] w_mutlak;
   logic [GW-1:0] w_genis;
   logic [m-1:0]  w_frac, w_frac_yuv;
   logic          w_g, w_s, w_yukari, w_tasma;
   logic [e-1:0]  w_exp_yuv;

   assign w_negatif = r_isaretli & r_tamsayi[IW-1];
   assign w_mutlak  = w_negatif ? (~r_tamsayi + IW'(1)) : r_tamsayi;

   // Fraction sits just below the hidden one; padding covers IW-1 < m and leaves room for G.
   assign w_genis   = {r_mag[IW-2:0], {(m + 2){1'b0}}};
   assign w_frac    = w_genis[GW-1 -: m];
   assign w_g       = w_genis[GW-1-m];
   assign w_s       = |w_genis[GW-2-m:0];
   assign w_yukari  = w_g & (w_s | w_frac[0]);
   assign {w_tasma, w_frac_yuv} = {1'b0, w_frac} + {{m{1'b0}}, w_yukari};
   assign w_exp_yuv = r_exp + {{(e - 1){1'b0}}, w_tasma};

`ifdef FAST_NORM_EN
   logic [$clog2(IW)-1:0] w_lzc;

   oncu_sifir_sayaci #(
      .IW (IW)
   ) u_oncu_sifir_sayaci (
      .i_veri (r_mag),
      .o_sayi (w_lzc)
   );
`endif

   always_comb begin
      w_durum    = r_durum;
      w_tamsayi  = r_tamsayi;
      w_isaretli = r_isaretli;
      w_isaret   = r_isaret;
      w_mag      = r_mag;
      w_exp      = r_exp;
      w_sonuc    = r_sonuc;
      case (r_durum)
         BOS: begin
            if (arayuz.start_i) begin
               w_tamsayi  = arayuz.tamsayi_i;
               w_isaretli = arayuz.isaretli_i;
               w_durum    = MUTLAK;
            end
         end
         MUTLAK: begin
            w_isaret = w_negatif;
            w_mag    = w_mutlak;
            w_exp    = EXP_BAS;
            if (w_mutlak == '0) begin
               w_sonuc = '0;
               w_durum = BITTI;
            end else begin
               w_durum = NORM;
            end
         end
         NORM: begin
`ifdef FAST_NORM_EN
            w_mag   = r_mag << w_lzc;
            w_exp   = r_exp - e'(w_lzc);
            w_durum = YUVARLA;
`else
            if (!r_mag[IW-1]) begin
               w_mag = r_mag << 1;
               w_exp = r_exp - e'(1);
            end else begin
               w_durum = YUVARLA;
            end
`endif
         end
         YUVARLA: begin
            w_sonuc = {r_isaret, w_exp_yuv, w_frac_yuv};
            w_durum = BITTI;
         end
         BITTI:   w_durum = BOS;
         default: w_durum = BOS;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_durum    <= BOS;
         r_tamsayi  <= '0;
         r_isaretli <= 1'b0;
         r_isaret   <= 1'b0;
         r_mag      <= '0;
         r_exp      <= '0;
         r_sonuc    <= '0;
         r_valid    <= 1'b0;
      end else if (en_i) begin
         r_durum    <= w_durum;
         r_tamsayi  <= w_tamsayi;
         r_isaretli <= w_isaretli;
         r_isaret   <= w_isaret;
         r_mag      <= w_mag;
         r_exp      <= w_exp;
         r_sonuc    <= w_sonuc;
         // Pulse rises on the edge that leaves BITTI and holds while en_i is low.
         r_valid    <= (r_durum == BITTI);
      end
   end

   assign arayuz.ready_o = (r_durum == BOS);
   assign arayuz.valid_o = r_valid;
   assign arayuz.sonuc_o = r_sonuc;
endmodule
